// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: executes 16-bit register commands received over the SPI link and
// drives the link's transmit side for replies and its long-word receive mode.
module spi_cmd_ctrl #(
   parameter int                   TIMEOUT_W = 24,
   parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 24'hFFFFFF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        received,
   input  logic [15:0] received_data,
   input  logic [47:0] long_dataIN,
   input  logic        busy,
   output logic        send_trigger,
   output logic [47:0] output_data,
   output logic [2:0]  SPI_MSG_TYPE,
   output logic [3:0]  InMsgByteCount,
   output logic        LongMsgComing,
   output logic [3:0]  reg_addr,
   output logic [7:0]  reg_wdata,
   output logic        reg_we,
   input  logic [7:0]  reg_rdata,
   output logic [47:0] long_word,
   output logic        long_valid,
   output logic [7:0]  status
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_DECODE    = 3'd1;
   localparam logic [2:0] S_LONG_WAIT = 3'd2;
   localparam logic [2:0] S_RESP_ARM  = 3'd3;
   localparam logic [2:0] S_RESP_DONE = 3'd4;

   localparam logic [3:0] OP_WRITE      = 4'd1;
   localparam logic [3:0] OP_READ       = 4'd2;
   localparam logic [3:0] OP_STATUS     = 4'd3;
   localparam logic [3:0] OP_LONG_WRITE = 4'd4;
   localparam logic [3:0] OP_LONG_READ  = 4'd5;

   localparam logic [2:0] TYPE_ONE_BY     = 3'd1;
   localparam logic [2:0] TYPE_STD_TWO_BY = 3'd2;
   localparam logic [2:0] TYPE_SIX_BY     = 3'd6;

   // Timer starts at 0 on state entry, so the wait lasts exactly TIMEOUT cycles.
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT - TIMEOUT_W'(1);

   logic [2:0]           state_q, state_d;
   logic [15:0]          cmd_q, cmd_d;
   logic [3:0]           reg_addr_q, reg_addr_d;
   logic [7:0]           reg_wdata_q, reg_wdata_d;
   logic                 reg_we_q, reg_we_d;
   logic [47:0]          out_data_q, out_data_d;
   logic [2:0]           msg_type_q, msg_type_d;
   logic                 send_q, send_d;
   logic                 long_coming_q, long_coming_d;
   logic [47:0]          long_word_q, long_word_d;
   logic                 long_valid_q, long_valid_d;
   logic [3:0]           err_cnt_q, err_cnt_d;
   logic                 overrun_q, overrun_d;
   logic                 timeout_q, timeout_d;
   logic                 bad_op_q, bad_op_d;
   logic                 long_avail_q, long_avail_d;
   logic [TIMEOUT_W-1:0] timer_q, timer_d;

   logic                 overrun_set, timeout_set, bad_op_set, clear_flags, timer_hit;
   logic [7:0]           status_w;

   assign status_w  = {err_cnt_q, overrun_q, timeout_q, bad_op_q, long_avail_q};
   assign timer_hit = (timer_q == TIMEOUT_LAST);

   always_comb begin
      state_d       = state_q;
      cmd_d         = cmd_q;
      reg_addr_d    = reg_addr_q;
      reg_wdata_d   = reg_wdata_q;
      reg_we_d      = 1'b0;
      out_data_d    = out_data_q;
      msg_type_d    = msg_type_q;
      send_d        = send_q;
      long_coming_d = long_coming_q;
      long_word_d   = long_word_q;
      long_valid_d  = 1'b0;
      long_avail_d  = long_avail_q;
      timer_d       = '0;
      overrun_set   = 1'b0;
      timeout_set   = 1'b0;
      bad_op_set    = 1'b0;
      clear_flags   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (received) begin
               cmd_d      = received_data;
               reg_addr_d = received_data[11:8];
               state_d    = S_DECODE;
            end
         end
         S_DECODE: begin
            overrun_set = received;
            state_d     = S_IDLE;
            case (cmd_q[15:12])
               OP_WRITE: begin
                  reg_wdata_d = cmd_q[7:0];
                  reg_we_d    = 1'b1;
               end
               OP_READ: begin
                  out_data_d = {32'h0, 4'h0, cmd_q[11:8], reg_rdata};
                  msg_type_d = TYPE_STD_TWO_BY;
                  send_d     = 1'b1;
                  state_d    = S_RESP_ARM;
               end
               OP_STATUS: begin
                  out_data_d  = {40'h0, status_w};
                  msg_type_d  = TYPE_ONE_BY;
                  clear_flags = 1'b1;
                  send_d      = 1'b1;
                  state_d     = S_RESP_ARM;
               end
               OP_LONG_WRITE: begin
                  long_coming_d = 1'b1;
                  state_d       = S_LONG_WAIT;
               end
               OP_LONG_READ: begin
                  out_data_d = long_word_q;
                  msg_type_d = TYPE_SIX_BY;
                  send_d     = 1'b1;
                  state_d    = S_RESP_ARM;
               end
               default: bad_op_set = 1'b1;
            endcase
         end
         S_LONG_WAIT: begin
            timer_d = timer_q + TIMEOUT_W'(1);
            if (timer_hit) begin
               timeout_set   = 1'b1;
               long_coming_d = 1'b0;
               state_d       = S_IDLE;
            end else if (received) begin
               long_word_d   = long_dataIN;
               long_valid_d  = 1'b1;
               long_avail_d  = 1'b1;
               long_coming_d = 1'b0;
               state_d       = S_IDLE;
            end
         end
         S_RESP_ARM: begin
            overrun_set = received;
            timer_d     = timer_q + TIMEOUT_W'(1);
            if (timer_hit) begin
               timeout_set = 1'b1;
               send_d      = 1'b0;
               state_d     = S_IDLE;
            end else if (busy) begin
               // Drop the trigger once the link has accepted it so it cannot re-fire.
               send_d  = 1'b0;
               timer_d = '0;
               state_d = S_RESP_DONE;
            end
         end
         S_RESP_DONE: begin
            overrun_set = received;
            timer_d     = timer_q + TIMEOUT_W'(1);
            if (timer_hit) begin
               timeout_set = 1'b1;
               state_d     = S_IDLE;
            end else if (!busy) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A flag raised in the same cycle as a STATUS clear survives.
      overrun_d = (overrun_q & ~clear_flags) | overrun_set;
      timeout_d = (timeout_q & ~clear_flags) | timeout_set;
      bad_op_d  = (bad_op_q  & ~clear_flags) | bad_op_set;
      err_cnt_d = err_cnt_q;
      if ((overrun_set || timeout_set || bad_op_set) && (err_cnt_q != 4'hF))
         err_cnt_d = err_cnt_q + 4'd1;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q       <= S_IDLE;
         cmd_q         <= '0;
         reg_addr_q    <= '0;
         reg_wdata_q   <= '0;
         reg_we_q      <= 1'b0;
         out_data_q    <= '0;
         msg_type_q    <= TYPE_STD_TWO_BY;
         send_q        <= 1'b0;
         long_coming_q <= 1'b0;
         long_word_q   <= '0;
         long_valid_q  <= 1'b0;
         err_cnt_q     <= '0;
         overrun_q     <= 1'b0;
         timeout_q     <= 1'b0;
         bad_op_q      <= 1'b0;
         long_avail_q  <= 1'b0;
         timer_q       <= '0;
      end else begin
         state_q       <= state_d;
         cmd_q         <= cmd_d;
         reg_addr_q    <= reg_addr_d;
         reg_wdata_q   <= reg_wdata_d;
         reg_we_q      <= reg_we_d;
         out_data_q    <= out_data_d;
         msg_type_q    <= msg_type_d;
         send_q        <= send_d;
         long_coming_q <= long_coming_d;
         long_word_q   <= long_word_d;
         long_valid_q  <= long_valid_d;
         err_cnt_q     <= err_cnt_d;
         overrun_q     <= overrun_d;
         timeout_q     <= timeout_d;
         bad_op_q      <= bad_op_d;
         long_avail_q  <= long_avail_d;
         timer_q       <= timer_d;
      end
   end

   assign send_trigger   = send_q;
   assign output_data    = out_data_q;
   assign SPI_MSG_TYPE   = msg_type_q;
   assign InMsgByteCount = 4'd6;
   assign LongMsgComing  = long_coming_q;
   assign reg_addr       = reg_addr_q;
   assign reg_wdata      = reg_wdata_q;
   assign reg_we         = reg_we_q;
   assign long_word      = long_word_q;
   assign long_valid     = long_valid_q;
   assign status         = status_w;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: scenario tasks with expected writes/replies queued at
// stimulus time and popped when the controller produces them.
module tb_spi_cmd_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        received = 1'b0;
   logic [15:0] received_data = '0;
   logic [47:0] long_dataIN = '0;
   logic        busy = 1'b0;
   logic [7:0]  rdata_drv = '0;
   logic        send_trigger;
   logic [47:0] output_data;
   logic [2:0]  SPI_MSG_TYPE;
   logic [3:0]  InMsgByteCount;
   logic        LongMsgComing;
   logic [3:0]  reg_addr;
   logic [7:0]  reg_wdata;
   logic        reg_we;
   logic [47:0] long_word;
   logic        long_valid;
   logic [7:0]  status;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [2:0]  typ;
      logic [47:0] data;
   } reply_t;
   typedef struct packed {
      logic [3:0] addr;
      logic [7:0] data;
   } wr_t;

   reply_t reply_q[$];
   wr_t    wr_q[$];

   localparam logic [126:0] RESET_VEC =
      {1'b0, 48'h0, 3'd2, 4'd6, 1'b0, 4'h0, 8'h0, 1'b0, 48'h0, 1'b0, 8'h0};

   spi_cmd_ctrl #(.TIMEOUT_W(24), .TIMEOUT(24'd16)) dut (
      .CLK(CLK), .RST(RST), .received(received), .received_data(received_data),
      .long_dataIN(long_dataIN), .busy(busy), .send_trigger(send_trigger),
      .output_data(output_data), .SPI_MSG_TYPE(SPI_MSG_TYPE),
      .InMsgByteCount(InMsgByteCount), .LongMsgComing(LongMsgComing),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
      .reg_rdata(rdata_drv), .long_word(long_word), .long_valid(long_valid),
      .status(status)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_cmd(input logic [15:0] w);
      received_data = w;
      received      = 1'b1;
      tick();
      received      = 1'b0;
   endtask

   task automatic apply_reset();
      RST = 1'b0;
      busy = 1'b0;
      received = 1'b0;
      tick();
      tick();
      RST = 1'b1;
      tick();
   endtask

   task automatic finish_reply();
      busy = 1'b1;
      tick();
      tick();
      busy = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      logic [126:0] obs;
      RST = 1'b0;
      tick();
      tick();
      obs = {send_trigger, output_data, SPI_MSG_TYPE, InMsgByteCount, LongMsgComing,
             reg_addr, reg_wdata, reg_we, long_word, long_valid, status};
      checks++;
      if (obs !== RESET_VEC) begin
         errors++;
         $display("FAIL reset_outputs: got %h required %h", obs, RESET_VEC);
      end
      RST = 1'b1;
      tick();
      checks++;
      if (InMsgByteCount !== 4'd6 || status !== 8'h00) begin
         errors++;
         $display("FAIL reset_release: bytecount=%0d status=%h required 6 / 00", InMsgByteCount, status);
      end
      $display("reset: outputs at reset values");
   endtask

   task automatic test_write();
      wr_t exp_w;
      wr_q.push_back('{addr: 4'hA, data: 8'h5C});
      pulse_cmd(16'h1A5C);
      checks++;
      if (reg_we !== 1'b0) begin
         errors++;
         $display("FAIL write_early: reg_we=%b required 0 one cycle after pulse", reg_we);
      end
      tick();
      exp_w = wr_q.pop_front();
      checks++;
      if (reg_we !== 1'b1 || reg_addr !== exp_w.addr || reg_wdata !== exp_w.data) begin
         errors++;
         $display("FAIL write_strobe: we=%b addr=%h data=%h required 1 %h %h",
                  reg_we, reg_addr, reg_wdata, exp_w.addr, exp_w.data);
      end
      tick();
      checks++;
      if (reg_we !== 1'b0) begin
         errors++;
         $display("FAIL write_pulse_width: reg_we=%b required 0", reg_we);
      end
      $display("write 1A5C: addr=%h data=%h", reg_addr, reg_wdata);
   endtask

   task automatic test_back_to_back();
      logic [15:0] words [4];
      wr_t exp_w;
      int n;
      words[0] = 16'h1011; words[1] = 16'h1122; words[2] = 16'h1F33; words[3] = 16'h1544;
      for (int i = 0; i < 4; i++) begin
         wr_q.push_back('{addr: words[i][11:8], data: words[i][7:0]});
         pulse_cmd(words[i]);
         n = 0;
         while (reg_we !== 1'b1 && n < 6) begin
            tick();
            n++;
         end
         exp_w = wr_q.pop_front();
         checks++;
         if (n != 1 || reg_addr !== exp_w.addr || reg_wdata !== exp_w.data) begin
            errors++;
            $display("FAIL b2b_write%0d: latency=%0d addr=%h data=%h required 1 %h %h",
                     i, n, reg_addr, reg_wdata, exp_w.addr, exp_w.data);
         end
         $display("b2b write %h: addr=%h data=%h", words[i], reg_addr, reg_wdata);
      end
      checks++;
      if (status !== 8'h00) begin
         errors++;
         $display("FAIL b2b_status: status=%h required 00", status);
      end
   endtask

   task automatic test_read();
      reply_t exp_r;
      int n;
      rdata_drv = 8'h77;
      reply_q.push_back('{typ: 3'd2, data: 48'h000000000377});
      pulse_cmd(16'h2300);
      n = 0;
      while (send_trigger !== 1'b1 && n < 6) begin
         tick();
         n++;
      end
      exp_r = reply_q.pop_front();
      checks++;
      if (n != 1 || {SPI_MSG_TYPE, output_data} !== exp_r) begin
         errors++;
         $display("FAIL read_reply: latency=%0d type=%0d data=%h required 1 %0d %h",
                  n, SPI_MSG_TYPE, output_data, exp_r.typ, exp_r.data);
      end
      tick();
      tick();
      checks++;
      if (send_trigger !== 1'b1) begin
         errors++;
         $display("FAIL read_hold: send_trigger=%b required 1 while busy low", send_trigger);
      end
      busy = 1'b1;
      tick();
      checks++;
      if (send_trigger !== 1'b0 || output_data !== exp_r.data) begin
         errors++;
         $display("FAIL read_drop: trigger=%b data=%h required 0 %h", send_trigger, output_data, exp_r.data);
      end
      tick();
      tick();
      checks++;
      if (send_trigger !== 1'b0 || SPI_MSG_TYPE !== 3'd2) begin
         errors++;
         $display("FAIL read_done_stable: trigger=%b type=%0d required 0 2", send_trigger, SPI_MSG_TYPE);
      end
      busy = 1'b0;
      tick();
      checks++;
      if (status !== 8'h00) begin
         errors++;
         $display("FAIL read_status: status=%h required 00", status);
      end
      $display("read 2300: type=%0d data=%h", exp_r.typ, exp_r.data);
   endtask

   task automatic test_bad_op_status();
      reply_t exp_r;
      logic [3:0] exp_cnt;
      int n;
      apply_reset();
      for (int i = 0; i < 17; i++) begin
         pulse_cmd(16'hF000);
         tick();
         exp_cnt = (i >= 14) ? 4'hF : 4'(i + 1);
         checks++;
         if (status !== {exp_cnt, 4'b0010}) begin
            errors++;
            $display("FAIL bad_op%0d: status=%h required %h", i, status, {exp_cnt, 4'b0010});
         end
         $display("bad op %0d: status=%h", i, status);
      end
      reply_q.push_back('{typ: 3'd1, data: 48'h0000000000F2});
      pulse_cmd(16'h3000);
      n = 0;
      while (send_trigger !== 1'b1 && n < 6) begin
         tick();
         n++;
      end
      exp_r = reply_q.pop_front();
      checks++;
      if (n != 1 || {SPI_MSG_TYPE, output_data} !== exp_r) begin
         errors++;
         $display("FAIL status_reply: latency=%0d type=%0d data=%h required 1 %0d %h",
                  n, SPI_MSG_TYPE, output_data, exp_r.typ, exp_r.data);
      end
      checks++;
      if (status !== 8'hF0) begin
         errors++;
         $display("FAIL status_clear: status=%h required F0", status);
      end
      finish_reply();
      $display("status 3000: type=%0d data=%h", exp_r.typ, exp_r.data);
   endtask

   task automatic test_long();
      reply_t exp_r;
      int n;
      apply_reset();
      pulse_cmd(16'h4000);
      checks++;
      if (LongMsgComing !== 1'b0) begin
         errors++;
         $display("FAIL long_early: LongMsgComing=%b required 0", LongMsgComing);
      end
      tick();
      tick();
      tick();
      checks++;
      if (LongMsgComing !== 1'b1) begin
         errors++;
         $display("FAIL long_wait: LongMsgComing=%b required 1", LongMsgComing);
      end
      long_dataIN = 48'h123456789ABC;
      received    = 1'b1;
      tick();
      received    = 1'b0;
      checks++;
      if (LongMsgComing !== 1'b0 || long_valid !== 1'b1 || long_word !== 48'h123456789ABC
          || status !== 8'h01) begin
         errors++;
         $display("FAIL long_capture: lmc=%b valid=%b word=%h status=%h required 0 1 123456789abc 01",
                  LongMsgComing, long_valid, long_word, status);
      end
      tick();
      checks++;
      if (long_valid !== 1'b0) begin
         errors++;
         $display("FAIL long_valid_width: long_valid=%b required 0", long_valid);
      end
      reply_q.push_back('{typ: 3'd6, data: 48'h123456789ABC});
      pulse_cmd(16'h5000);
      n = 0;
      while (send_trigger !== 1'b1 && n < 6) begin
         tick();
         n++;
      end
      exp_r = reply_q.pop_front();
      checks++;
      if (n != 1 || {SPI_MSG_TYPE, output_data} !== exp_r) begin
         errors++;
         $display("FAIL long_read_reply: latency=%0d type=%0d data=%h required 1 %0d %h",
                  n, SPI_MSG_TYPE, output_data, exp_r.typ, exp_r.data);
      end
      finish_reply();
      $display("long write/read: type=%0d data=%h", exp_r.typ, exp_r.data);
   endtask

   task automatic test_timeout();
      int high_cycles;
      apply_reset();
      rdata_drv = 8'h11;
      pulse_cmd(16'h2100);
      tick();
      high_cycles = 0;
      while (send_trigger === 1'b1 && high_cycles < 40) begin
         tick();
         high_cycles++;
      end
      checks++;
      if (high_cycles != 16) begin
         errors++;
         $display("FAIL timeout_len: trigger high %0d cycles required 16", high_cycles);
      end
      checks++;
      if (status !== 8'h14 || send_trigger !== 1'b0) begin
         errors++;
         $display("FAIL timeout_flag: status=%h trigger=%b required 14 0", status, send_trigger);
      end
      pulse_cmd(16'h1299);
      tick();
      checks++;
      if (reg_we !== 1'b1 || reg_wdata !== 8'h99) begin
         errors++;
         $display("FAIL timeout_idle: we=%b wdata=%h required 1 99", reg_we, reg_wdata);
      end
      $display("timeout: trigger high %0d cycles, status=%h", high_cycles, status);
   endtask

   task automatic test_overrun();
      apply_reset();
      rdata_drv = 8'h42;
      pulse_cmd(16'h2500);
      tick();
      busy = 1'b1;
      tick();
      pulse_cmd(16'h1ABC);
      checks++;
      if (status !== 8'h18 || send_trigger !== 1'b0) begin
         errors++;
         $display("FAIL overrun_flag: status=%h trigger=%b required 18 0", status, send_trigger);
      end
      tick();
      checks++;
      if (reg_we !== 1'b0 || reg_wdata !== 8'h00) begin
         errors++;
         $display("FAIL overrun_discard: we=%b wdata=%h required 0 00", reg_we, reg_wdata);
      end
      busy = 1'b0;
      tick();
      $display("overrun: status=%h", status);
   endtask

   task automatic test_reset_mid();
      logic [126:0] obs;
      apply_reset();
      rdata_drv = 8'h5A;
      pulse_cmd(16'h2700);
      tick();
      checks++;
      if (send_trigger !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_arm: send_trigger=%b required 1", send_trigger);
      end
      RST = 1'b0;
      tick();
      obs = {send_trigger, output_data, SPI_MSG_TYPE, InMsgByteCount, LongMsgComing,
             reg_addr, reg_wdata, reg_we, long_word, long_valid, status};
      checks++;
      if (obs !== RESET_VEC) begin
         errors++;
         $display("FAIL reset_mid_outputs: got %h required %h", obs, RESET_VEC);
      end
      RST = 1'b1;
      tick();
      $display("reset mid RESP_ARM: outputs at reset values");
   endtask

   initial begin
      test_reset();
      test_write();
      test_back_to_back();
      test_read();
      test_bad_op_status();
      test_long();
      test_timeout();
      test_overrun();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
